// File: rtl/fetch_pc_predictor.sv
// Fetch PC generator with a direct-mapped, tagged branch target table and 2-bit counters.
// Trains from execute-stage branch resolutions and repairs the PC on redirect.
module fetch_pc_predictor #(
  parameter int unsigned BHT_ENTRIES = 64,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall_ip,
  input  logic        ex_branch_valid_ip,
  input  logic        ex_jump_valid_ip,
  input  logic        ex_taken_ip,
  input  logic        ex_flush_ip,
  input  logic [31:0] ex_target_ip,
  input  logic [31:0] ex_pc_ip,
  output logic [31:0] pc_op,
  output logic        pc_valid_op,
  output logic        prediction_op,
  output logic [31:0] mispredict_count_op
);

  localparam int unsigned IdxW = $clog2(BHT_ENTRIES);
  localparam int unsigned TagW = 32 - IdxW - 2;

  typedef logic [IdxW-1:0] idx_t;
  typedef logic [TagW-1:0] tag_t;

  // Table storage; only valid and counter bits need a reset value.
  logic [BHT_ENTRIES-1:0] valid_q;
  logic [1:0]             ctr_q    [BHT_ENTRIES];
  tag_t                   tag_q    [BHT_ENTRIES];
  logic [31:0]            target_q [BHT_ENTRIES];

  logic [31:0] pc_q, pc_d;
  logic        pc_valid_q;
  logic [31:0] mispredict_q, mispredict_d;

  // Fetch-side lookup
  idx_t fetch_idx;
  tag_t fetch_tag;
  logic fetch_hit;
  logic predict_taken;

  assign fetch_idx     = pc_q[IdxW+1:2];
  assign fetch_tag     = pc_q[31:IdxW+2];
  assign fetch_hit     = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
  assign predict_taken = reset && pc_valid_q && fetch_hit && ctr_q[fetch_idx][1];

  // Training-side lookup
  idx_t train_idx;
  tag_t train_tag;
  logic train_hit;
  logic ctr_we;
  logic [1:0] ctr_wdata;
  logic tgt_we;
  logic alloc_we;

  assign train_idx = ex_pc_ip[IdxW+1:2];
  assign train_tag = ex_pc_ip[31:IdxW+2];
  assign train_hit = valid_q[train_idx] && (tag_q[train_idx] == train_tag);

  always_comb begin
    ctr_we    = 1'b0;
    ctr_wdata = ctr_q[train_idx];
    tgt_we    = 1'b0;
    alloc_we  = 1'b0;
    if (ex_branch_valid_ip) begin
      if (train_hit) begin
        ctr_we = 1'b1;
        if (ex_taken_ip) begin
          tgt_we    = 1'b1;
          ctr_wdata = (ctr_q[train_idx] == 2'b11) ? 2'b11 : ctr_q[train_idx] + 2'b01;
        end else begin
          ctr_wdata = (ctr_q[train_idx] == 2'b00) ? 2'b00 : ctr_q[train_idx] - 2'b01;
        end
      end else if (ex_taken_ip) begin
        // Cold allocation starts weakly taken.
        alloc_we  = 1'b1;
        tgt_we    = 1'b1;
        ctr_we    = 1'b1;
        ctr_wdata = 2'b10;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
    end else begin
      if (alloc_we) valid_q[train_idx] <= 1'b1;
      if (ctr_we)   ctr_q[train_idx]   <= ctr_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset && alloc_we) tag_q[train_idx]    <= train_tag;
    if (reset && tgt_we)   target_q[train_idx] <= ex_target_ip;
  end

  // Next-PC selection
  logic redirect_jump;
  logic redirect_branch;

  assign redirect_jump   = ex_flush_ip && ex_jump_valid_ip;
  assign redirect_branch = ex_flush_ip && ex_branch_valid_ip;

  always_comb begin
    pc_d = pc_q;
    // The first valid cycle after reset must present RESET_PC itself.
    if (!pc_valid_q) begin
      pc_d = pc_q;
    end else if (redirect_jump) begin
      pc_d = ex_target_ip;
    end else if (redirect_branch && ex_taken_ip) begin
      pc_d = ex_target_ip;
    end else if (redirect_branch) begin
      pc_d = ex_pc_ip + 32'd4;
    end else if (stall_ip) begin
      pc_d = pc_q;
    end else if (predict_taken) begin
      pc_d = target_q[fetch_idx];
    end else begin
      pc_d = pc_q + 32'd4;
    end
  end

  assign mispredict_d = redirect_branch ? mispredict_q + 32'd1 : mispredict_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      pc_q         <= RESET_PC;
      pc_valid_q   <= 1'b0;
      mispredict_q <= 32'd0;
    end else begin
      pc_q         <= pc_d;
      pc_valid_q   <= 1'b1;
      mispredict_q <= mispredict_d;
    end
  end

  assign pc_op               = pc_q;
  assign pc_valid_op         = pc_valid_q;
  assign prediction_op       = predict_taken;
  assign mispredict_count_op = mispredict_q;

  flush_has_source: assert property (@(posedge clock) disable iff (!reset)
      ex_flush_ip |-> (ex_branch_valid_ip || ex_jump_valid_ip))
    else $error("fetch_pc_predictor: flush without branch or jump");

  branch_jump_exclusive: assert property (@(posedge clock) disable iff (!reset)
      !(ex_branch_valid_ip && ex_jump_valid_ip))
    else $error("fetch_pc_predictor: branch and jump resolved together");

endmodule

// File: doc/fetch_pc_predictor.md
Name: fetch_pc_predictor

Overview:
Fetch-side PC generator and dynamic branch predictor. It is the consumer of the execute stage's redirect interface: taken, flush, next-PC, and the resolved-branch PC.
- Produces the fetch PC each cycle.
- Predicts conditional branches with a direct-mapped table of tagged targets and 2-bit saturating counters.
- Supplies the prediction bit that travels down the pipe as the execute stage's prediction input.
- Trains the table from execute-stage resolutions and repairs the PC on mispredict.

Parameters:
BHT_ENTRIES, 64, number of predictor entries; power of two, >= 2.
RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
clock  in  1  core clock.
reset  in  1  synchronous, active-low reset.
stall_ip  in  1  hazard-unit stall; hold PC.
ex_branch_valid_ip  in  1  conditional branch resolved in EX this cycle (comparator valid, OFFSET selection).
ex_jump_valid_ip  in  1  JAL/JALR resolved in EX this cycle.
ex_taken_ip  in  1  branch outcome from EX.
ex_flush_ip  in  1  EX flush request.
ex_target_ip  in  32  EX next-PC address; the taken target for branches, the jump target for jumps.
ex_pc_ip  in  32  PC of the instruction being resolved in EX.
pc_op  out  32  current fetch address.
pc_valid_op  out  1  pc_op is a real fetch.
prediction_op  out  1  predicted-taken for the instruction at pc_op.
mispredict_count_op  out  32  count of flushes caused by conditional branches.

Behaviour:
- Index and tag: IDX = log2(BHT_ENTRIES). index = pc[IDX+1:2]; tag = pc[31:IDX+2]. Each entry holds valid, tag, 32-bit target and a 2-bit counter.
- Reset (reset==0 at posedge):
  - pc_op = RESET_PC, pc_valid_op = 0, mispredict_count_op = 0.
  - All entries: valid = 0, counter = 2'b01.
  - prediction_op reads 0 while in reset.
  - Reset asserted mid-operation discards any pending redirect.
- First cycle after reset release: pc_op = RESET_PC, pc_valid_op = 1. pc_valid_op stays 1 until the next reset.
- Lookup (combinational on pc_op):
  - hit = valid && tag match.
  - prediction_op = hit && counter[1], gated by pc_valid_op.
- Next-PC priority (registered at posedge, highest first):
  1. ex_flush_ip && ex_jump_valid_ip -> ex_target_ip.
  2. ex_flush_ip && ex_branch_valid_ip && ex_taken_ip -> ex_target_ip.
  3. ex_flush_ip && ex_branch_valid_ip && !ex_taken_ip -> ex_pc_ip + 4.
  4. stall_ip -> hold pc_op.
  5. prediction_op -> hit entry's target.
  6. otherwise pc_op + 4.
- Flush always overrides stall.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
- ex_flush_ip with neither ex_branch_valid_ip nor ex_jump_valid_ip is illegal: it is ignored and flagged by a simulation assertion. ex_branch_valid_ip and ex_jump_valid_ip are never both 1.
- Training: on ex_branch_valid_ip only, indexed by ex_pc_ip. Takes effect at posedge and is independent of stall.
  - Hit, taken: counter saturating +1 (max 11); target <= ex_target_ip.
  - Hit, not taken: counter saturating -1 (min 00).
  - Miss, taken: allocate/replace with valid=1, tag, target=ex_target_ip, counter=2'b10.
  - Miss, not taken: no change.
  - Jumps never train the table.
- Same-cycle lookup and update of the same index: lookup sees the pre-update entry; the update is visible next cycle.
- mispredict_count_op increments by 1 on each cycle with ex_flush_ip && ex_branch_valid_ip. It wraps at 2^32.
- No wrong-path squashing inside this block; the downstream flush controller owns that.

Test Plan:
- Reset low 3 cycles, then release, stall=0 -> pc_op=0 with pc_valid_op=0 during reset; then pc_op 0,4,8,12 with pc_valid_op=1 and prediction_op=0.
- Cold taken branch: ex_branch_valid=1, taken=1, flush=1, ex_pc=0x10, target=0x40 -> next pc_op=0x40; entry 4 valid with counter 10. Later pc_op=0x10 -> prediction_op=1 and next pc_op=0x40; mispredict_count=1.
- Predicted branch at 0x10 resolves not-taken with flush -> next pc_op=0x14; counter 10->01; next visit to 0x10 gives prediction_op=0 and pc_op advances to 0x14.
- Saturation: four taken resolutions at 0x10 -> counter 11; one not-taken -> counter 10 and prediction_op still 1. Three more not-taken -> counter 00, and it stays at 00.
- Stall=1 for 3 cycles -> pc_op held. Stall=1 together with flush, jump_valid=1, target=0x200 -> next pc_op=0x200, and mispredict_count unchanged.
- Alias: train taken at ex_pc=0x10, then fetch pc_op=0x110 (same index 4, different tag) -> prediction_op=0, next pc_op=0x114.
